// File: rtl/fft_frame_arbiter.sv
// Frame-level round-robin arbiter sharing one window/FFT input stream between two sample channels.
// Optional starvation timeout with zero padding of the stalled frame: define ARB_STARVE_TIMEOUT_EN.
module fft_frame_arbiter #(
  parameter int unsigned FFT_SIZE   = 4096,
  parameter int unsigned DATA_WIDTH = 16
`ifdef ARB_STARVE_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s0_frame_req,
  input  logic                  s0_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  output logic                  s0_axis_tready,
  input  logic                  s1_frame_req,
  input  logic                  s1_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  output logic                  s1_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_err
);

  localparam int unsigned CW = $clog2(FFT_SIZE);
  localparam logic [CW-1:0] LAST_BEAT = CW'(FFT_SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1
`ifdef ARB_STARVE_TIMEOUT_EN
    ,
    ST_PAD    = 2'd2
`endif
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_beat_cnt, w_beat_cnt_nxt;
  logic            r_grant, w_grant_nxt;
  logic            r_last_grant, w_last_grant_nxt;
  logic            r_frame_done, w_frame_done_nxt;
  logic            w_src_valid;
  logic [DATA_WIDTH-1:0] w_src_data;
  logic            w_is_last;

`ifdef ARB_STARVE_TIMEOUT_EN
  localparam int unsigned SW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STALL_LIMIT = SW'(TIMEOUT_CYCLES - 1);

  logic            r_frame_err, w_frame_err_nxt;
  logic [SW-1:0]   r_stall_cnt, w_stall_cnt_nxt;

  assign frame_err = r_frame_err;
`else
  assign frame_err = 1'b0;
`endif

  assign frame_done  = r_frame_done;
  assign w_src_valid = r_grant ? s1_axis_tvalid : s0_axis_tvalid;
  assign w_src_data  = r_grant ? s1_axis_tdata : s0_axis_tdata;
  assign w_is_last   = (r_beat_cnt == LAST_BEAT);

  // Next-state and combinational stream mux; the only path from sources to the FFT is zero-latency.
  always_comb begin
    w_state_nxt      = r_state;
    w_beat_cnt_nxt   = r_beat_cnt;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_frame_done_nxt = 1'b0;
`ifdef ARB_STARVE_TIMEOUT_EN
    w_frame_err_nxt  = 1'b0;
    w_stall_cnt_nxt  = r_stall_cnt;
`endif
    m_axis_tvalid    = 1'b0;
    m_axis_tdata     = '0;
    m_axis_tlast     = 1'b0;
    m_axis_tuser     = 1'b0;
    busy             = 1'b0;
    s0_axis_tready   = 1'b0;
    s1_axis_tready   = 1'b0;

    case (r_state)
      ST_IDLE: begin
`ifdef ARB_STARVE_TIMEOUT_EN
        w_stall_cnt_nxt = '0;
`endif
        if (s0_frame_req || s1_frame_req) begin
          w_grant_nxt    = (s0_frame_req && s1_frame_req) ? ~r_last_grant : s1_frame_req;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = ST_STREAM;
        end
      end

      ST_STREAM: begin
        busy           = 1'b1;
        m_axis_tvalid  = w_src_valid;
        m_axis_tdata   = w_src_data;
        m_axis_tuser   = r_grant;
        m_axis_tlast   = w_is_last && w_src_valid;
        s0_axis_tready = ~r_grant & m_axis_tready;
        s1_axis_tready = r_grant & m_axis_tready;
        if (w_src_valid && m_axis_tready) begin
          w_beat_cnt_nxt = r_beat_cnt + CW'(1);
          if (w_is_last) begin
            w_state_nxt      = ST_IDLE;
            w_last_grant_nxt = r_grant;
            w_frame_done_nxt = 1'b1;
          end
        end
`ifdef ARB_STARVE_TIMEOUT_EN
        // Only an idle source counts as a stall; FFT back-pressure never does.
        if (w_src_valid) begin
          w_stall_cnt_nxt = '0;
        end else if (r_stall_cnt == STALL_LIMIT) begin
          w_stall_cnt_nxt = '0;
          w_state_nxt     = ST_PAD;
        end else begin
          w_stall_cnt_nxt = r_stall_cnt + SW'(1);
        end
`endif
      end

`ifdef ARB_STARVE_TIMEOUT_EN
      // Fill the rest of a starved frame with zeros so the FFT frame stays aligned.
      ST_PAD: begin
        busy          = 1'b1;
        m_axis_tvalid = 1'b1;
        m_axis_tuser  = r_grant;
        m_axis_tlast  = w_is_last;
        if (m_axis_tready) begin
          w_beat_cnt_nxt = r_beat_cnt + CW'(1);
          if (w_is_last) begin
            w_state_nxt      = ST_IDLE;
            w_last_grant_nxt = r_grant;
            w_frame_done_nxt = 1'b1;
            w_frame_err_nxt  = 1'b1;
          end
        end
      end
`endif

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // last_grant resets to 1 so channel 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_beat_cnt   <= '0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_frame_done <= 1'b0;
`ifdef ARB_STARVE_TIMEOUT_EN
      r_frame_err  <= 1'b0;
      r_stall_cnt  <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_frame_done <= w_frame_done_nxt;
`ifdef ARB_STARVE_TIMEOUT_EN
      r_frame_err  <= w_frame_err_nxt;
      r_stall_cnt  <= w_stall_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Directed bench for fft_frame_arbiter: combinational mux table plus frame-level sequences.
module tb_fft_frame_arbiter;

  localparam int unsigned FFT = 4096;
  localparam int unsigned DW  = 16;

  logic          clk;
  logic          reset;
  logic          s0_frame_req, s0_axis_tvalid, s0_axis_tready;
  logic [DW-1:0] s0_axis_tdata;
  logic          s1_frame_req, s1_axis_tvalid, s1_axis_tready;
  logic [DW-1:0] s1_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          busy, frame_done, frame_err;

  fft_frame_arbiter #(
    .FFT_SIZE(FFT),
    .DATA_WIDTH(DW)
`ifdef ARB_STARVE_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .s0_frame_req(s0_frame_req), .s0_axis_tvalid(s0_axis_tvalid),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tready(s0_axis_tready),
    .s1_frame_req(s1_frame_req), .s1_axis_tvalid(s1_axis_tvalid),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tready(s1_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_tready(m_axis_tready), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Source model state: channel N sends ramp data (N<<12 | ptr mod FFT) until ptr reaches its stop.
  logic manual, mon_en, rand_ready;
  int   s0_ptr, s1_ptr, s0_stop, s1_stop, pad_from;
  logic hs0, hs1;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      s0_ptr = 0;
      s1_ptr = 0;
    end else begin
      if (hs0) s0_ptr++;
      if (hs1) s1_ptr++;
    end
    if (!manual) begin
      s0_axis_tvalid = (s0_ptr < s0_stop);
      s0_axis_tdata  = DW'(s0_ptr % FFT);
      s1_axis_tvalid = (s1_ptr < s1_stop);
      s1_axis_tdata  = 16'h1000 | DW'(s1_ptr % FFT);
      m_axis_tready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  typedef struct {
    int   beats;
    int   data_bad;
    int   tlast_cnt;
    int   ng_bad;
    logic tuser;
    logic tlast_end;
    logic done_ok;
    logic err;
    logic busy_after;
  } frame_rec_t;

  function automatic frame_rec_t empty_rec();
    frame_rec_t r;
    r.beats = 0; r.data_bad = 0; r.tlast_cnt = 0; r.ng_bad = 0;
    r.tuser = 1'b0; r.tlast_end = 1'b0; r.done_ok = 1'b0; r.err = 1'b0; r.busy_after = 1'b0;
    return r;
  endfunction

  frame_rec_t frames[$];
  frame_rec_t cur;
  int   idx;
  logic pend;
  int   spurious_done;
  logic [DW-1:0] exp_data;

  // Output monitor: counts handshakes per frame and grades data, tlast, tready and frame_done.
  always @(negedge clk) begin
    hs0 = !manual && !reset && s0_axis_tvalid && s0_axis_tready;
    hs1 = !manual && !reset && s1_axis_tvalid && s1_axis_tready;
    if (reset) begin
      idx  = 0;
      pend = 1'b0;
      cur  = empty_rec();
    end else if (mon_en) begin
      if (pend) begin
        cur.done_ok    = frame_done;
        cur.err        = frame_err;
        cur.busy_after = busy;
        frames.push_back(cur);
        cur  = empty_rec();
        idx  = 0;
        pend = 1'b0;
      end else if (frame_done) begin
        spurious_done++;
      end
      if (busy) begin
        if (idx == 0) cur.tuser = m_axis_tuser;
        if (m_axis_tuser ? s0_axis_tready : s1_axis_tready) cur.ng_bad++;
        if (m_axis_tvalid && m_axis_tready) begin
          exp_data = (idx >= pad_from) ? '0 : ((m_axis_tuser ? 16'h1000 : 16'h0000) | DW'(idx));
          if (m_axis_tdata !== exp_data) cur.data_bad++;
          if (m_axis_tlast) begin
            cur.tlast_cnt++;
            if (idx == FFT - 1) cur.tlast_end = 1'b1;
          end
          idx++;
          cur.beats++;
          if (idx == FFT) pend = 1'b1;
        end
      end
    end
  end

  task automatic wait_busy(input string tag, input int budget);
    int c = 0;
    while (!busy && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    chk({tag, ".busy_seen"}, busy, 1'b1);
  endtask

  task automatic wait_idx(input string tag, input int n, input int budget);
    int c = 0;
    while (idx < n && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    chk({tag, ".beat_reached"}, 64'(idx >= n), 1);
  endtask

  task automatic wait_frames(input string tag, input int n, input int budget);
    int c = 0;
    while (frames.size() < n && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    chk({tag, ".frames_seen"}, 64'(frames.size() >= n), 1);
  endtask

  task automatic check_frame(input string tag, input logic exp_user, input logic exp_err);
    frame_rec_t r;
    if (frames.size() > 0) begin
      r = frames.pop_front();
      chk({tag, ".tuser"}, r.tuser, exp_user);
      chk({tag, ".beats"}, r.beats, FFT);
      chk({tag, ".data_errors"}, r.data_bad, 0);
      chk({tag, ".tlast_count"}, r.tlast_cnt, 1);
      chk({tag, ".tlast_on_last"}, r.tlast_end, 1'b1);
      chk({tag, ".other_tready"}, r.ng_bad, 0);
      chk({tag, ".frame_done"}, r.done_ok, 1'b1);
      chk({tag, ".frame_err"}, r.err, exp_err);
      chk({tag, ".gap_busy"}, r.busy_after, 1'b0);
    end
  endtask

  typedef struct {
    logic          s0v;
    logic [DW-1:0] s0d;
    logic          s1v;
    logic [DW-1:0] s1d;
    logic          rdy;
    logic [19:0]   exp;  // {m_tvalid, m_tdata, s0_tready, s1_tready, m_tlast}
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 16'h1234, 1'b1, 16'hBEEF, 1'b1, {1'b1, 16'h1234, 1'b1, 1'b0, 1'b0}};
    vecs[1] = '{1'b0, 16'h5555, 1'b1, 16'hBEEF, 1'b1, {1'b0, 16'h5555, 1'b1, 1'b0, 1'b0}};
    vecs[2] = '{1'b1, 16'hA5A5, 1'b0, 16'h0F0F, 1'b0, {1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0}};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b0, {1'b0, 16'h0000, 1'b0, 1'b0, 1'b0}};
    vecs[4] = '{1'b1, 16'hFFFF, 1'b0, 16'h7777, 1'b1, {1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0}};
    vecs[5] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, {1'b0, 16'h0000, 1'b0, 1'b0, 1'b0}};

    clk = 1'b0; reset = 1'b1;
    s0_frame_req = 1'b0; s1_frame_req = 1'b0;
    s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
    s0_axis_tdata = '0; s1_axis_tdata = '0; m_axis_tready = 1'b0;
    manual = 1'b1; mon_en = 1'b1; rand_ready = 1'b0;
    s0_ptr = 0; s1_ptr = 0; s0_stop = 1 << 30; s1_stop = 1 << 30; pad_from = FFT;
    hs0 = 1'b0; hs1 = 1'b0; idx = 0; pend = 1'b0; spurious_done = 0; cur = empty_rec();

    #1;
    chk("reset.ctrl_outputs",
        {m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy, frame_done, frame_err, s0_axis_tready, s1_axis_tready}, 0);
    chk("reset.tdata", m_axis_tdata, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Arbitration latency: request seen in IDLE at N, busy at N+1.
    @(posedge clk); #1;
    s0_frame_req = 1'b1;
    @(negedge clk); #1;
    chk("latency.idle_busy", busy, 1'b0);
    @(negedge clk); #1;
    chk("latency.grant_busy", busy, 1'b1);
    chk("latency.grant_tuser", m_axis_tuser, 1'b0);
    s0_frame_req = 1'b0;

    // Combinational mux table, all within one clock phase, ending with no handshake.
    mon_en = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      s0_axis_tvalid = vecs[i].s0v; s0_axis_tdata = vecs[i].s0d;
      s1_axis_tvalid = vecs[i].s1v; s1_axis_tdata = vecs[i].s1d;
      m_axis_tready  = vecs[i].rdy;
      #1;
      chk($sformatf("mux.vec%0d", i),
          {m_axis_tvalid, m_axis_tdata, s0_axis_tready, s1_axis_tready, m_axis_tlast}, vecs[i].exp);
    end
    manual = 1'b0;
    mon_en = 1'b1;

    wait_frames("ch0_single", 1, 6000);
    check_frame("ch0_single", 1'b0, 1'b0);

    // Back-pressure from the FFT side must not lose or duplicate beats.
    rand_ready = 1'b1;
    s0_frame_req = 1'b1;
    wait_busy("ch0_bp", 20);
    s0_frame_req = 1'b0;
    wait_frames("ch0_bp", 1, 12000);
    check_frame("ch0_bp", 1'b0, 1'b0);
    rand_ready = 1'b0;

    // Request withdrawn mid-frame: the frame still runs to its full length.
    s1_frame_req = 1'b1;
    wait_busy("ch1_drop", 20);
    wait_idx("ch1_drop", 1000, 2000);
    s1_frame_req = 1'b0;
    wait_frames("ch1_drop", 1, 6000);
    check_frame("ch1_drop", 1'b1, 1'b0);

    // Reset at beat 2000 clears outputs without a clock edge.
    s0_frame_req = 1'b1;
    wait_busy("midreset", 20);
    s0_frame_req = 1'b0;
    wait_idx("midreset", 2000, 3000);
    #1 reset = 1'b1;
    #1;
    chk("midreset.ctrl_outputs",
        {m_axis_tvalid, m_axis_tlast, busy, s0_axis_tready, s1_axis_tready}, 0);
    chk("midreset.tdata", m_axis_tdata, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    chk("midreset.no_frame", frames.size(), 0);
    chk("midreset.no_done", spurious_done, 0);

    // Both requests held: ch0 first after reset, then strict alternation.
    s0_frame_req = 1'b1;
    s1_frame_req = 1'b1;
    wait_frames("alternate", 4, 4 * (FFT + 10) + 50);
    s0_frame_req = 1'b0;
    s1_frame_req = 1'b0;
    for (int i = 0; i < 4; i++) check_frame($sformatf("alternate%0d", i), 1'(i % 2), 1'b0);

    // Source starves after 100 beats.
    s0_stop  = s0_ptr + 100;
    pad_from = 100;
    s0_frame_req = 1'b1;
    wait_busy("starve", 20);
    s0_frame_req = 1'b0;
`ifdef ARB_STARVE_TIMEOUT_EN
    wait_frames("starve", 1, FFT + 200);
    check_frame("starve", 1'b0, 1'b1);
`else
    repeat (300) @(negedge clk);
    #1;
    chk("starve.stuck_busy", busy, 1'b1);
    chk("starve.beats_sent", idx, 100);
    chk("starve.no_frame", frames.size(), 0);
`endif
    chk("global.spurious_done", spurious_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_frame_arbiter.md
Name: fft_frame_arbiter

Overview:
- Frame-level round-robin arbiter that shares one windowing/FFT pipeline between two sample channels (stereo L/R).
- Each upstream source raises a frame request once it holds a full frame. The arbiter grants one channel for exactly FFT_SIZE beats, muxes it onto the FFT input stream, generates tlast and a channel tag, then re-arbitrates.
- Sits between the per-channel sample buffers and the shared window/FFT chain.

Parameters:
- FFT_SIZE, 4096, beats per frame (power of two, >= 4).
- DATA_WIDTH, 16, sample width on all streams.
- TIMEOUT_CYCLES, 1024, starvation limit; used only when ARB_STARVE_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- s0_frame_req  in  1  channel 0 has a full frame ready.
- s0_axis_tvalid  in  1  channel 0 sample valid.
- s0_axis_tdata  in  DATA_WIDTH  channel 0 sample.
- s0_axis_tready  out  1  channel 0 ready.
- s1_frame_req, s1_axis_tvalid, s1_axis_tdata, s1_axis_tready: same as channel 0, for channel 1.
- m_axis_tvalid  out  1  FFT input valid.
- m_axis_tdata  out  DATA_WIDTH  FFT input sample.
- m_axis_tlast  out  1  last beat of frame.
- m_axis_tuser  out  1  channel id of current frame.
- m_axis_tready  in  1  FFT input ready.
- busy  out  1  high while a frame is granted.
- frame_done  out  1  one-cycle pulse after a frame's last beat.
- frame_err  out  1  one-cycle pulse with frame_done if the frame was padded.

Behaviour:
- Reset: asynchronous, active-high. Effects:
  - state=IDLE, beat_cnt=0, grant_q=0, last_grant_q=1 (so ch0 wins the first tie).
  - All outputs 0; both s*_axis_tready=0.
  - Reset mid-frame abandons the frame immediately. No tlast and no frame_done are emitted.
- States: IDLE, STREAM, PAD (PAD exists only with the macro).
- IDLE:
  - Requests are sampled every cycle.
  - Only one request asserted: grant that channel.
  - Both asserted: grant ~last_grant_q.
  - On a grant: grant_q<=channel, beat_cnt<=0, state<=STREAM.
  - No output activity; busy=0.
- STREAM:
  - busy=1.
  - m_axis_tvalid = granted source tvalid; m_axis_tdata = granted tdata.
  - Granted s*_axis_tready = m_axis_tready. Non-granted tready = 0.
  - Mux is combinational, so source-to-FFT latency is 0 cycles.
  - m_axis_tuser = grant_q.
  - m_axis_tlast = (beat_cnt == FFT_SIZE-1) and m_axis_tvalid.
  - On each handshake (m_axis_tvalid & m_axis_tready), beat_cnt increments.
  - Handshake on beat FFT_SIZE-1: state<=IDLE, last_grant_q<=grant_q, beat_cnt<=0, frame_done pulses next cycle.
- Arbitration latency: a request seen in IDLE at cycle N gives busy=1 at N+1. The first beat can be accepted at N+1.
- Minimum gap between frames: one IDLE cycle.
- Requests that change during STREAM/PAD are ignored. Only the transfer count ends a frame.
- m_axis_tready low: hold beat_cnt and state. Data stability is the source's responsibility; the arbiter adds no state.
- Width rule: beat_cnt is $clog2(FFT_SIZE) bits and wraps naturally to 0 at frame end.

Optional Feature:
- Macro: ARB_STARVE_TIMEOUT_EN.
- Defined:
  - In STREAM, a stall counter counts consecutive cycles where granted tvalid=0. It clears on any granted tvalid=1.
  - Reaching TIMEOUT_CYCLES: state<=PAD.
  - PAD: m_axis_tvalid=1, m_axis_tdata=0, both source treadies 0. beat_cnt continues and tlast rules are unchanged.
  - On the last handshake in PAD: return to IDLE; frame_done and frame_err pulse together next cycle; last_grant_q updates.
  - Stalls caused by m_axis_tready=0 do not count toward the timeout.
- Undefined: no stall counter and no PAD state. STREAM waits indefinitely; frame_err is tied 0.

Test Plan:
- Reset, then s0_frame_req=1 only, source always valid, FFT always ready, ramp data 0..4095: 4096 beats with tuser=0, tlast only on beat 4095 (data 4095), frame_done pulse one cycle later, busy low for >=1 cycle.
- Both requests held high continuously: frames alternate tuser 0,1,0,1; each frame is exactly 4096 beats; s1_axis_tready stays 0 throughout ch0 frames.
- Ch0 streaming, m_axis_tready toggled 50% randomly: beat count is still 4096, no beat lost or duplicated, output data order matches input order.
- Assert reset at beat 2000 of a frame: outputs go 0 immediately without waiting for a clock edge; after release, with both requests high, ch0 is granted first.
- s1_frame_req drops mid-frame while ch1 is streaming: frame completes all 4096 beats and tlast asserts.
- With ARB_STARVE_TIMEOUT_EN and TIMEOUT_CYCLES=16: source stops at beat 100. After 16 stall cycles, 3996 zero beats are emitted, then tlast; frame_done and frame_err pulse together. Without the macro, the same stimulus leaves the frame stuck with busy=1.
